// File: rtl/mdu_pkg.sv
// rtl/mdu_pkg.sv - shared types and helpers for the multiply/divide unit
// Purpose: operation and state enums, default width, count-width helper and
//          small op-decode functions used by mdu and its bench.
// Ports:   none (package).
package mdu_pkg;

  typedef enum logic [1:0] {
    MDU_MULTU = 2'b00,
    MDU_MULT  = 2'b01,
    MDU_DIVU  = 2'b10,
    MDU_DIV   = 2'b11
  } mdu_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    FIX  = 2'b10,
    DONE = 2'b11
  } mdu_state_t;

  localparam int MDU_N_DEFAULT = 32;

  // Iteration counter must hold the value N itself, hence the extra bit.
  function automatic int mdu_cnt_w(input int n);
    return $clog2(n) + 1;
  endfunction

  function automatic logic op_is_div(input mdu_op_t op);
    return (op == MDU_DIVU) || (op == MDU_DIV);
  endfunction

  function automatic logic op_is_signed(input mdu_op_t op);
    return (op == MDU_MULT) || (op == MDU_DIV);
  endfunction

endpackage

// File: rtl/mdu_div_step.sv
// rtl/mdu_div_step.sv - one combinational restoring-division step
// Purpose: shift the next dividend bit into the partial remainder and
//          subtract the divisor when it fits.
// Ports:   rem          in  N  current partial remainder (always < divisor)
//          dividend_msb in  1  next dividend bit to shift in
//          divisor      in  N  divisor magnitude
//          rem_next     out N  partial remainder after this step
//          q_bit        out 1  quotient bit produced by this step
module mdu_div_step
  import mdu_pkg::*;
#(
  parameter int N = MDU_N_DEFAULT
) (
  input  logic [N-1:0] rem,
  input  logic         dividend_msb,
  input  logic [N-1:0] divisor,
  output logic [N-1:0] rem_next,
  output logic         q_bit
);

  logic [N:0] shifted;
  logic [N:0] diff;

  // rem < divisor, so the shifted value is below 2*divisor and the N+1-bit
  // difference borrows (top bit set) exactly when the divisor does not fit.
  always_comb begin
    shifted  = {rem, dividend_msb};
    diff     = shifted - {1'b0, divisor};
    q_bit    = ~diff[N];
    rem_next = q_bit ? diff[N-1:0] : shifted[N-1:0];
  end

endmodule

// File: rtl/mdu.sv
// rtl/mdu.sv - iterative radix-2 multiply/divide unit with start/busy/done
// Purpose: MULTU/MULT/DIVU/DIV over N iterations, sign-corrected in FIX.
// Ports:   clk          in  1  rising-edge clock
//          rst_n        in  1  synchronous active-low reset
//          start        in  1  request, sampled only in IDLE
//          op           in  2  00 MULTU, 01 MULT, 10 DIVU, 11 DIV
//          a, b         in  N  multiplicand/dividend, multiplier/divisor
//          busy         out 1  RUN or FIX
//          done         out 1  one-cycle pulse, hi/lo valid from here
//          hi, lo       out N  product words, or remainder/quotient
//          div_by_zero  out 1  divide with b==0, cleared on next start
module mdu
  import mdu_pkg::*;
#(
  parameter int N = MDU_N_DEFAULT
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [1:0]   op,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] hi,
  output logic [N-1:0] lo,
  output logic         div_by_zero
);

  localparam int CW = mdu_cnt_w(N);

  mdu_state_t      state;
  mdu_op_t         op_q;
  logic [CW-1:0]   count;
  logic            sa, sb;
  logic            dbz_q;
  logic [N-1:0]    mag_a, mag_b;
  logic [2*N-1:0]  acc;
  logic [N-1:0]    rem, quo;

  mdu_op_t         op_in;
  logic            a_neg_in, b_neg_in, b_zero_in;
  logic [N-1:0]    mag_a_in, mag_b_in;
  logic [N:0]      mult_sum;
  logic [2*N-1:0]  acc_next;
  logic [N-1:0]    rem_next;
  logic            q_bit;
  logic [2*N-1:0]  prod_fix;
  logic [N-1:0]    quo_fix, rem_fix, a_fix;

  assign busy = (state == RUN) || (state == FIX);

  always_comb begin
    op_in     = mdu_op_t'(op);
    a_neg_in  = op_is_signed(op_in) & a[N-1];
    b_neg_in  = op_is_signed(op_in) & b[N-1];
    b_zero_in = (b == '0);
    mag_a_in  = a_neg_in ? -a : a;
    mag_b_in  = b_neg_in ? -b : b;
  end

  // Shift-add: low half of acc holds the unconsumed multiplier bits, the
  // high half accumulates; the carry lands in the top bit after the shift.
  always_comb begin
    mult_sum = {1'b0, acc[2*N-1:N]} + (acc[0] ? {1'b0, mag_a} : '0);
    acc_next = {mult_sum, acc[N-1:1]};
  end

  // quo starts as the dividend and shifts left, trading dividend bits for
  // quotient bits one per step.
  mdu_div_step #(.N(N)) u_div_step (
    .rem          (rem),
    .dividend_msb (quo[N-1]),
    .divisor      (mag_b),
    .rem_next     (rem_next),
    .q_bit        (q_bit)
  );

  always_comb begin
    prod_fix = (sa ^ sb) ? -acc : acc;
    quo_fix  = (sa ^ sb) ? -quo : quo;
    rem_fix  = sa ? -rem : rem;
    // Rebuilds the original a from its magnitude for the divide-by-zero case.
    a_fix    = sa ? -mag_a : mag_a;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      op_q        <= MDU_MULTU;
      count       <= '0;
      sa          <= 1'b0;
      sb          <= 1'b0;
      dbz_q       <= 1'b0;
      mag_a       <= '0;
      mag_b       <= '0;
      acc         <= '0;
      rem         <= '0;
      quo         <= '0;
      done        <= 1'b0;
      hi          <= '0;
      lo          <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            op_q        <= op_in;
            sa          <= a_neg_in;
            sb          <= b_neg_in;
            mag_a       <= mag_a_in;
            mag_b       <= mag_b_in;
            count       <= CW'(N);
            acc         <= {{N{1'b0}}, mag_b_in};
            rem         <= '0;
            quo         <= mag_a_in;
            div_by_zero <= 1'b0;
            dbz_q       <= op_is_div(op_in) & b_zero_in;
            state       <= (op_is_div(op_in) && b_zero_in) ? FIX : RUN;
          end
        end
        RUN: begin
          count <= count - CW'(1);
          if (op_is_div(op_q)) begin
            rem <= rem_next;
            quo <= {quo[N-2:0], q_bit};
          end else begin
            acc <= acc_next;
          end
          if (count == CW'(1)) state <= FIX;
        end
        FIX: begin
          if (dbz_q) begin
            hi <= a_fix;
            lo <= '1;
          end else if (op_is_div(op_q)) begin
            hi <= rem_fix;
            lo <= quo_fix;
          end else begin
            hi <= prod_fix[2*N-1:N];
            lo <= prod_fix[N-1:0];
          end
          div_by_zero <= dbz_q;
          done        <= 1'b1;
          state       <= DONE;
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
